// File: rtl/tdm_demux8_1.sv
//------------------------------------------------------------------------------
// tdm_demux8_1 : TDM 8-slot receive demux; frame_sync-locked, registered frame out
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux8_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  input  logic             frame_sync_i,
  output logic [WIDTH-1:0] y0_o,
  output logic [WIDTH-1:0] y1_o,
  output logic [WIDTH-1:0] y2_o,
  output logic [WIDTH-1:0] y3_o,
  output logic [WIDTH-1:0] y4_o,
  output logic [WIDTH-1:0] y5_o,
  output logic [WIDTH-1:0] y6_o,
  output logic [WIDTH-1:0] y7_o,
  output logic             frame_valid_o,
  output logic [2:0]       slot_o,
  output logic             locked_o,
  output logic             sync_err_o
);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow_q [7];
  logic [WIDTH-1:0] shadow_d [7];
  logic [WIDTH-1:0] y_q [8];
  logic [WIDTH-1:0] y_d [8];
  logic             fv_q, fv_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
      slot_q  <= 3'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int k = 0; k < 7; k++) shadow_q[k] <= '0;
      for (int k = 0; k < 8; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      for (int k = 0; k < 7; k++) shadow_q[k] <= shadow_d[k];
      for (int k = 0; k < 8; k++) y_q[k] <= y_d[k];
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    for (int k = 0; k < 7; k++) shadow_d[k] = shadow_q[k];
    for (int k = 0; k < 8; k++) y_d[k] = y_q[k];

    if (din_valid_i) begin
      unique case (state_q)
        S_HUNT: begin
          if (frame_sync_i) begin
            shadow_d[0] = din_i;
            slot_d      = 3'd1;
            state_d     = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (frame_sync_i && (slot_q != 3'd0)) begin
            // Misplaced marker: drop the partial frame and restart at slot 0.
            err_d       = 1'b1;
            shadow_d[0] = din_i;
            slot_d      = 3'd1;
          end else begin
            slot_d = slot_q + 3'd1;
            if (slot_q == 3'd7) begin
              for (int k = 0; k < 7; k++) y_d[k] = shadow_q[k];
              y_d[7] = din_i;
              fv_d   = 1'b1;
            end else begin
              for (int k = 0; k < 7; k++) begin
                if (slot_q == 3'(k)) shadow_d[k] = din_i;
              end
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  assign y0_o          = y_q[0];
  assign y1_o          = y_q[1];
  assign y2_o          = y_q[2];
  assign y3_o          = y_q[3];
  assign y4_o          = y_q[4];
  assign y5_o          = y_q[5];
  assign y6_o          = y_q[6];
  assign y7_o          = y_q[7];
  assign frame_valid_o = fv_q;
  assign slot_o        = slot_q;
  assign locked_o      = (state_q == S_LOCKED);
  assign sync_err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8_1.sv
//------------------------------------------------------------------------------
// tb_tdm_demux8_1 : randomized bench for tdm_demux8_1 (WIDTH=4 and WIDTH=1 copies)
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux8_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] din4 = '0;
  logic       vld = 1'b0;
  logic       sync = 1'b0;

  logic [3:0] y4 [8];
  logic       fv4, lk4, er4;
  logic [2:0] slot4;
  logic [0:0] y1 [8];
  logic       fv1, lk1, er1;
  logic [2:0] slot1;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of samples collected for the frame in progress.
  logic [3:0] q [$];
  logic [3:0] m_y [8];
  bit         m_locked, m_fv, m_err;

  always #5 clk = ~clk;

  tdm_demux8_1 #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .din_i(din4), .din_valid_i(vld), .frame_sync_i(sync),
    .y0_o(y4[0]), .y1_o(y4[1]), .y2_o(y4[2]), .y3_o(y4[3]),
    .y4_o(y4[4]), .y5_o(y4[5]), .y6_o(y4[6]), .y7_o(y4[7]),
    .frame_valid_o(fv4), .slot_o(slot4), .locked_o(lk4), .sync_err_o(er4)
  );

  tdm_demux8_1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .din_i(din4[0]), .din_valid_i(vld), .frame_sync_i(sync),
    .y0_o(y1[0]), .y1_o(y1[1]), .y2_o(y1[2]), .y3_o(y1[3]),
    .y4_o(y1[4]), .y5_o(y1[5]), .y6_o(y1[6]), .y7_o(y1[7]),
    .frame_valid_o(fv1), .slot_o(slot1), .locked_o(lk1), .sync_err_o(er1)
  );

  function automatic logic [51:0] obs();
    return {y4[0], y4[1], y4[2], y4[3], y4[4], y4[5], y4[6], y4[7],
            fv4, slot4, lk4, er4,
            y1[0], y1[1], y1[2], y1[3], y1[4], y1[5], y1[6], y1[7],
            fv1, slot1, lk1, er1};
  endfunction

  function automatic logic [51:0] expv();
    logic [2:0] s;
    s = 3'(q.size());
    return {m_y[0], m_y[1], m_y[2], m_y[3], m_y[4], m_y[5], m_y[6], m_y[7],
            m_fv, s, m_locked, m_err,
            m_y[0][0], m_y[1][0], m_y[2][0], m_y[3][0],
            m_y[4][0], m_y[5][0], m_y[6][0], m_y[7][0],
            m_fv, s, m_locked, m_err};
  endfunction

  // Drive one cycle, advance the model across the edge, then settle past it.
  task automatic step(input bit v, input bit s, input logic [3:0] d, input bit rn);
    @(negedge clk);
    vld = v; sync = s; din4 = d; rst_n = rn;
    @(posedge clk);
    m_fv = 0; m_err = 0;
    if (!rn) begin
      q.delete(); m_locked = 0;
      for (int k = 0; k < 8; k++) m_y[k] = '0;
    end else if (v) begin
      if (s) begin
        if (m_locked && q.size() != 0) m_err = 1;
        q.delete(); q.push_back(d); m_locked = 1;
      end else if (m_locked) begin
        q.push_back(d);
        if (q.size() == 8) begin
          for (int k = 0; k < 8; k++) m_y[k] = q[k];
          m_fv = 1; q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 1);
  endtask

  task automatic test_reset();
    step(1, 1, 4'hF, 0);
    if (obs() !== expv()) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs(), expv());
    end
    checks++;
    if (lk4 !== 1'b0 || slot4 !== 3'd0) begin
      failures++; $display("FAIL reset_lock got=%b/%0d exp=0/0", lk4, slot4);
    end
    checks++;
    step(0, 0, 4'h0, 1);
  endtask

  task automatic test_basic_frame();
    logic [7:0] pat;
    pat = 8'b0100_1101;  // slot k carries pat[k]: 1,0,1,1,0,0,1,0
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, k == 0, {3'b000, pat[k]}, 1);
      if (obs() !== expv()) begin
        failures++; $display("FAIL basic_beat%0d got=%h exp=%h", k, obs(), expv());
      end
      checks++;
    end
    if (fv1 !== 1'b1 || slot1 !== 3'd0 || lk1 !== 1'b1 || y1[2] !== 1'b1 || y1[1] !== 1'b0) begin
      failures++; $display("FAIL basic_frame got=fv%b slot%0d lk%b exp=fv1 slot0 lk1", fv1, slot1, lk1);
    end
    checks++;
    step(0, 0, 4'h0, 1);
    if (fv1 !== 1'b0 || obs() !== expv()) begin
      failures++; $display("FAIL basic_pulse got=%h exp=%h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_hunt();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 4'(k + 3), 1);
      if (obs() !== expv() || lk4 !== 1'b0) begin
        failures++; $display("FAIL hunt_discard%0d got=%h exp=%h", k, obs(), expv());
      end
      checks++;
    end
    step(1, 1, 4'h9, 1);
    if (obs() !== expv() || lk4 !== 1'b1 || slot4 !== 3'd1) begin
      failures++; $display("FAIL hunt_lock got=%h exp=%h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_sync_err();
    do_reset();
    for (int k = 0; k < 4; k++) step(1, k == 0, 4'($urandom), 1);
    step(1, 1, 4'hA, 1);
    if (obs() !== expv() || er4 !== 1'b1 || slot4 !== 3'd1) begin
      failures++; $display("FAIL syncerr_pulse got=%h exp=%h", obs(), expv());
    end
    checks++;
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 4'($urandom), 1);
      if (obs() !== expv()) begin
        failures++; $display("FAIL syncerr_refill%0d got=%h exp=%h", k, obs(), expv());
      end
      checks++;
    end
    if (fv4 !== 1'b1 || y4[0] !== 4'hA) begin
      failures++; $display("FAIL syncerr_frame got=fv%b y0=%h exp=fv1 y0=a", fv4, y4[0]);
    end
    checks++;
    // Marker on slot 7 wins: no frame, error instead.
    for (int k = 0; k < 7; k++) step(1, k == 0, 4'($urandom), 1);
    step(1, 1, 4'h3, 1);
    if (obs() !== expv() || fv4 !== 1'b0 || er4 !== 1'b1) begin
      failures++; $display("FAIL syncerr_slot7 got=%h exp=%h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        step(1, k == 0, 4'($urandom), 1);
        if (obs() !== expv()) begin
          failures++; $display("FAIL b2b_beat f%0d s%0d got=%h exp=%h", f, k, obs(), expv());
        end
        checks++;
        if (fv4) pulses++;
        for (int g = $urandom_range(0, 3); g > 0; g--) begin
          step(0, $urandom_range(0, 1) == 1, 4'($urandom), 1);
          if (obs() !== expv()) begin
            failures++; $display("FAIL b2b_idle got=%h exp=%h", obs(), expv());
          end
          checks++;
          if (fv4) pulses++;
        end
      end
    end
    if (pulses != 2) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 8; k++) step(1, k == 0, 4'($urandom), 1);
    for (int k = 0; k < 5; k++) step(1, k == 0, 4'($urandom), 1);
    step(1, 1, 4'h7, 0);
    if (obs() !== expv() || lk4 !== 1'b0 || slot4 !== 3'd0 || y4[3] !== 4'h0) begin
      failures++; $display("FAIL reset_mid got=%h exp=%h", obs(), expv());
    end
    checks++;
    step(1, 0, 4'h5, 1);
    if (obs() !== expv() || lk4 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_hunt got=%h exp=%h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_width4();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 8; k++) begin
        step(1, k == 0, 4'(k + 8), 1);
        if (obs() !== expv() || er4 !== 1'b0) begin
          failures++; $display("FAIL w4_beat f%0d s%0d got=%h exp=%h", f, k, obs(), expv());
        end
        checks++;
      end
      if (y4[0] !== 4'd8 || y4[5] !== 4'd13 || y4[7] !== 4'd15 || fv4 !== 1'b1) begin
        failures++; $display("FAIL w4_frame got=%h,%h,%h exp=8,d,f", y4[0], y4[5], y4[7]);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, 4'($urandom),
           $urandom_range(0, 149) != 0);
      if (obs() !== expv()) begin
        failures++; $display("FAIL random_c%0d got=%h exp=%h", c, obs(), expv());
      end
      checks++;
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) m_y[k] = '0;
    m_locked = 0; m_fv = 0; m_err = 0;
    test_reset();
    test_basic_frame();
    test_hunt();
    test_sync_err();
    test_back_to_back();
    test_reset_mid();
    test_width4();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux8_1.md
Name: tdm_demux8_1

Overview:
- Receive-side counterpart of the 8:1 channel mux.
- Takes a time-division-multiplexed serial stream (one channel sample per accepted beat, eight slots per frame) and steers each sample into its slot.
- Presents a complete 8-channel frame on parallel registered outputs y0..y7, with a one-cycle frame_valid strobe.
- Locks to the stream using a frame_sync marker on slot 0 and flags misaligned markers.

Parameters:
- WIDTH, 1, bit width of each channel sample (din and each of y0..y7).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- din  input  WIDTH  serial channel sample for the current slot
- din_valid  input  1  din/frame_sync are accepted on this clk edge when high
- frame_sync  input  1  qualified by din_valid; marks the accepted beat as slot 0
- y0..y7  output  WIDTH each  registered channel outputs of last complete frame (y0 = slot 0 ... y7 = slot 7)
- frame_valid  output  1  one-cycle pulse: y0..y7 just updated with a new frame
- slot  output  3  slot index the next accepted beat will be written to
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse: frame_sync accepted while slot != 0 in LOCKED

Behaviour:
- Reset (rst_n low at clk edge, synchronous, overrides all other inputs): state=HUNT, slot=0, y0..y7=0, shadow regs=0, frame_valid=0, sync_err=0, locked=0.
- Beat = clk edge with rst_n=1 and din_valid=1. Non-beat cycles: no state change except frame_valid/sync_err return to 0.
- frame_valid and sync_err are registered pulses, high exactly one cycle after the causing beat's edge, otherwise 0.
- State HUNT:
  - beats without frame_sync are discarded, slot stays 0.
  - beat with frame_sync: shadow[0]<=din, slot<=1, state<=LOCKED.
- State LOCKED, beat with frame_sync=0:
  - shadow[slot]<=din, slot<=slot+1 (3-bit wrap 7->0).
  - if slot==7: y0..y6<=shadow[0..6], y7<=din, frame_valid=1 next cycle; y outputs and frame_valid change on the same edge (output latency one edge after the slot-7 beat).
- State LOCKED, beat with frame_sync=1 and slot==0: normal slot-0 beat (shadow[0]<=din, slot<=1), no error.
- State LOCKED, beat with frame_sync=1 and slot!=0 (misalignment):
  - sync_err=1 next cycle; partial frame discarded (y0..y7 unchanged, no frame_valid).
  - resync: shadow[0]<=din, slot<=1, remain LOCKED.
  - applies also at slot==7: frame_sync wins, no frame output.
- Frame outputs hold their value until the next complete frame or reset.
- Continuous back-to-back beats: one frame_valid every 8 beats, no bubbles required.
- locked = (state==LOCKED); slot output is the live counter.
- Reset mid-frame: partial frame lost, outputs cleared, must re-see frame_sync.
- No unlock path other than reset.

Test Plan:
- Reset then 8 beats din=1,0,1,1,0,0,1,0 (frame_sync on first, WIDTH=1) -> edge after 8th beat: y0..y7=1,0,1,1,0,0,1,0, frame_valid high exactly 1 cycle, slot=0, locked=1.
- After reset, 3 beats with frame_sync=0 then frame_sync beat -> slot stays 0 and locked=0 for first 3; locked=1, slot=1 after 4th.
- Locked, 4 beats into frame, beat with frame_sync=1 -> sync_err pulse 1 cycle, y0..y7 unchanged, slot=1; next 7 beats yield frame_valid with new data.
- Two back-to-back frames with din_valid gaps of 0..3 random idle cycles between beats -> two frame_valid pulses, each y value matches its slot, no change during idles.
- Assert rst_n=0 for one cycle at slot 5 -> next edge all y=0, slot=0, locked=0, no frame_valid/sync_err.
- WIDTH=4, slot k carries value k+8 -> y0..y7=8..15 after frame; frame_sync asserted at slot 0 of the second frame gives no sync_err.
